// File: rtl/param_serializer.sv
// Parallel-to-serial converter with configurable width, bit order and optional parity bit.
// Bits advance only on ser_en strobes; ser_done marks the cycle the frame's last bit appears.
`timescale 1ns/1ps

module param_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter bit MSB_FIRST  = 1'b0,
    parameter bit PARITY_EN  = 1'b0,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  ser_en,
    output logic                  s_data,
    output logic                  ser_busy,
    output logic                  ser_done
);

    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        PARITY
    } state_t;

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] shreg, shreg_nxt, shreg_shifted;
    logic [CW-1:0]         cnt, cnt_nxt;
    logic                  par_bit, par_bit_nxt;
    logic                  s_data_nxt, ser_done_nxt;
    logic                  out_bit;
    logic                  last_bit;

    assign in_ready = (state == IDLE);
    assign ser_busy = (state != IDLE);
    assign last_bit = (cnt == CW'(DATA_WIDTH - 1));

    // Outgoing bit sits at the end selected by MSB_FIRST; the register shifts toward it.
    always_comb begin
        if (MSB_FIRST) begin
            out_bit       = shreg[DATA_WIDTH-1];
            shreg_shifted = {shreg[DATA_WIDTH-2:0], 1'b0};
        end else begin
            out_bit       = shreg[0];
            shreg_shifted = {1'b0, shreg[DATA_WIDTH-1:1]};
        end
    end

    always_comb begin
        state_nxt    = state;
        shreg_nxt    = shreg;
        cnt_nxt      = cnt;
        par_bit_nxt  = par_bit;
        s_data_nxt   = s_data;
        ser_done_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    shreg_nxt   = p_data;
                    cnt_nxt     = '0;
                    par_bit_nxt = (^p_data) ^ PARITY_ODD;
                    state_nxt   = SHIFT;
                end
            end
            SHIFT: begin
                if (ser_en) begin
                    s_data_nxt = out_bit;
                    shreg_nxt  = shreg_shifted;
                    cnt_nxt    = cnt + CW'(1);
                    if (last_bit) begin
                        if (PARITY_EN) begin
                            state_nxt = PARITY;
                        end else begin
                            state_nxt    = IDLE;
                            ser_done_nxt = 1'b1;
                        end
                    end
                end
            end
            PARITY: begin
                if (ser_en) begin
                    s_data_nxt   = par_bit;
                    ser_done_nxt = 1'b1;
                    state_nxt    = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            shreg    <= '0;
            cnt      <= '0;
            par_bit  <= 1'b0;
            s_data   <= 1'b0;
            ser_done <= 1'b0;
        end else begin
            state    <= state_nxt;
            shreg    <= shreg_nxt;
            cnt      <= cnt_nxt;
            par_bit  <= par_bit_nxt;
            s_data   <= s_data_nxt;
            ser_done <= ser_done_nxt;
        end
    end

endmodule

// File: tb/tb_param_serializer.sv
// Scoreboard bench for param_serializer: four configurations share one clock; stimulus
// queues expected serial bits and a negedge monitor checks every emitted bit and idle cycle.
`timescale 1ns/1ps

module tb_param_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  p8;
    logic [15:0] p16;
    logic [3:0]  vld, rdy, en, sd, busy, done;

    typedef struct packed {
        logic [1:0] inst;
        logic       b;
        logic       last;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   checks = 0;
    int   failures = 0;

    logic       c_rst = 1'b1;
    logic [3:0] c_busy = '0;
    logic [3:0] c_en = '0;
    logic [3:0] prev_sd = '0;

    always #5 clk = ~clk;

    param_serializer u0 (
        .clk(clk), .rst(rst), .p_data(p8), .in_valid(vld[0]), .in_ready(rdy[0]),
        .ser_en(en[0]), .s_data(sd[0]), .ser_busy(busy[0]), .ser_done(done[0])
    );

    param_serializer #(.DATA_WIDTH(8), .MSB_FIRST(1'b1), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u1 (
        .clk(clk), .rst(rst), .p_data(p8), .in_valid(vld[1]), .in_ready(rdy[1]),
        .ser_en(en[1]), .s_data(sd[1]), .ser_busy(busy[1]), .ser_done(done[1])
    );

    param_serializer #(.DATA_WIDTH(8), .MSB_FIRST(1'b0), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u2 (
        .clk(clk), .rst(rst), .p_data(p8), .in_valid(vld[2]), .in_ready(rdy[2]),
        .ser_en(en[2]), .s_data(sd[2]), .ser_busy(busy[2]), .ser_done(done[2])
    );

    param_serializer #(.DATA_WIDTH(16)) u3 (
        .clk(clk), .rst(rst), .p_data(p16), .in_valid(vld[3]), .in_ready(rdy[3]),
        .ser_en(en[3]), .s_data(sd[3]), .ser_busy(busy[3]), .ser_done(done[3])
    );

    task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s u%0d got=%0h want=%0h", name, inst, act, want);
        end
    endtask

    // Expected bit stream of one frame; only the first 'upto' entries are queued.
    task automatic push_frame(input int inst, input logic [15:0] word, input int w,
                              input bit msb, input bit pe, input bit po, input int upto);
        exp_t e;
        int   idx;
        int   n;
        n = 0;
        for (int i = 0; i < w; i++) begin
            idx    = msb ? (w - 1 - i) : i;
            e.inst = inst[1:0];
            e.b    = word[idx];
            e.last = (i == w - 1) && !pe;
            if (n < upto) q.push_back(e);
            n++;
        end
        if (pe && n < upto) begin
            e.inst = inst[1:0];
            e.b    = (^word) ^ po;
            e.last = 1'b1;
            q.push_back(e);
        end
    endtask

    task automatic send(input int inst, input logic [15:0] word);
        int c;
        c = 0;
        while (!rdy[inst] && c < 50) begin
            @(posedge clk); #1;
            c++;
        end
        chk("ready_before_send", inst, rdy[inst], 1);
        if (inst == 3) p16 = word;
        else p8 = word[7:0];
        vld[inst] = 1'b1;
        @(posedge clk); #1;
        vld[inst] = 1'b0;
    endtask

    task automatic drain(input int maxc);
        int c;
        c = 0;
        while (q.size() != 0 && c < maxc) begin
            @(negedge clk); #1;
            c++;
        end
        chk("drain_timeout", 0, q.size(), 0);
        if (q.size() != 0) q.delete();
    endtask

    always @(posedge clk) begin
        c_rst  <= rst;
        c_busy <= busy;
        c_en   <= en;
    end

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (c_rst) begin
                chk("rst_s_data", i, sd[i], 0);
                chk("rst_ser_done", i, done[i], 0);
                chk("rst_in_ready", i, rdy[i], 1);
                chk("rst_ser_busy", i, busy[i], 0);
            end else if (c_busy[i] && c_en[i]) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_bit u%0d got=%0b want=none", i, sd[i]);
                end else begin
                    m_e = q.pop_front();
                    chk("frame_owner", i, i, m_e.inst);
                    chk("s_data", i, sd[i], m_e.b);
                    chk("ser_done", i, done[i], m_e.last);
                    if (m_e.last) chk("ready_after_done", i, rdy[i], 1);
                end
            end else begin
                chk("done_quiet", i, done[i], 0);
                chk("s_data_hold", i, sd[i], prev_sd[i]);
            end
        end
        prev_sd = sd;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int cyc;
        logic [3:0] pat;
        rst = 1'b1;
        en  = 4'b1111;
        vld = '0;
        p8  = '0;
        p16 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", 0, rdy, 4'hF);
        chk("reset_busy", 0, busy, 4'h0);
        rst = 1'b0;

        // LSB first, no parity: A5 -> 1,0,1,0,0,1,0,1
        push_frame(0, 16'h00A5, 8, 0, 0, 0, 99);
        send(0, 16'h00A5);
        drain(40);

        // MSB first, even parity: 81 -> 1,0,0,0,0,0,0,1 then 0
        push_frame(1, 16'h0081, 8, 1, 1, 0, 99);
        send(1, 16'h0081);
        drain(40);

        // Odd parity: 07 -> parity 0, 03 -> parity 1
        push_frame(2, 16'h0007, 8, 0, 1, 1, 99);
        send(2, 16'h0007);
        drain(40);
        push_frame(2, 16'h0003, 8, 0, 1, 1, 99);
        send(2, 16'h0003);
        drain(40);

        // ser_en pattern 1-0-0-1 through a frame: exactly 8 enabled edges until done
        en[0] = 1'b0;
        pat   = 4'b1001;
        push_frame(0, 16'h00C3, 8, 0, 0, 0, 99);
        send(0, 16'h00C3);
        n = 0;
        for (int k = 0; k < 64; k++) begin
            en[0] = pat[k % 4];
            @(posedge clk);
            if (en[0]) n++;
            @(negedge clk); #1;
            if (q.size() == 0) break;
        end
        en[0] = 1'b1;
        chk("en_high_edges", 0, n, 8);
        drain(40);

        // Reset after 3 bits of 3C (0,0,1): frame aborts, then FF gives eight 1s
        push_frame(0, 16'h003C, 8, 0, 0, 0, 3);
        send(0, 16'h003C);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_idle", 0, busy[0], 0);
        chk("abort_ready", 0, rdy[0], 1);
        rst = 1'b0;
        @(negedge clk); #1;
        chk("abort_bits_seen", 0, q.size(), 0);
        push_frame(0, 16'h00FF, 8, 0, 0, 0, 99);
        send(0, 16'h00FF);
        drain(40);

        // 16-bit back-to-back with in_valid held high
        push_frame(3, 16'hBEEF, 16, 0, 0, 0, 99);
        push_frame(3, 16'h1234, 16, 0, 0, 0, 99);
        p16    = 16'hBEEF;
        vld[3] = 1'b1;
        @(posedge clk); #1;
        p16 = 16'h1234;
        cyc = 0;
        while (!rdy[3] && cyc < 64) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("b2b_gap", 3, cyc, 16);
        @(posedge clk); #1;
        vld[3] = 1'b0;
        chk("b2b_capture", 3, busy[3], 1);
        drain(80);

        repeat (3) @(posedge clk);
        #1;
        chk("final_queue", 0, q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/param_serializer.md
PARAM_SERIALIZER -- requirements
Module: param_serializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, the parallel word width; legal values are 2 to 32.
REQ-002 SHALL have parameter MSB_FIRST, default 0: 0 shifts bit 0 first, 1 shifts bit DATA_WIDTH-1 first.
REQ-003 SHALL have parameter PARITY_EN, default 0: 1 appends one parity bit after the data bits.
REQ-004 SHALL have parameter PARITY_ODD, default 0: 0 gives even parity, 1 gives odd parity; ignored when PARITY_EN=0.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port p_data, input, DATA_WIDTH bits: the parallel word to serialize.
REQ-008 SHALL have port in_valid, input, 1 bit: p_data is valid.
REQ-009 SHALL have port in_ready, output, 1 bit: the block accepts a word (combinational, high only in IDLE).
REQ-010 SHALL have port ser_en, input, 1 bit: the shift-advance strobe; while low, no bit is emitted.
REQ-011 SHALL have port s_data, output, 1 bit, registered: the serial data bit.
REQ-012 SHALL have port ser_busy, output, 1 bit: high while in SHIFT or PARITY.
REQ-013 SHALL have port ser_done, output, 1 bit, registered: a one-cycle pulse when the last bit of a frame is driven.

Function
REQ-014 SHALL implement the FSM states IDLE, SHIFT and PARITY.
REQ-015 IDLE: on a clock edge with in_valid=1, SHALL capture p_data into the shift register, clear the bit counter, latch the parity bit (XOR of p_data, inverted if PARITY_ODD), and go to SHIFT; otherwise it stays in IDLE.
REQ-016 A word SHALL be accepted only when in_valid and in_ready are both 1; p_data SHALL be ignored outside IDLE.
REQ-017 SHIFT: on each edge with ser_en=1, SHALL drive the next bit onto s_data in the order set by MSB_FIRST, shift the register, and increment the counter; with ser_en=0, all state holds.
REQ-018 The bit counter SHALL be $clog2(DATA_WIDTH+1) bits wide and SHALL never exceed DATA_WIDTH.
REQ-019 On the edge that drives data bit DATA_WIDTH-1 (counter=DATA_WIDTH-1), SHALL go to PARITY if PARITY_EN=1, else go to IDLE and pulse ser_done.
REQ-020 PARITY: on the next edge with ser_en=1, SHALL drive the latched parity bit on s_data, pulse ser_done, and go to IDLE.
REQ-021 ser_done SHALL be high for exactly one cycle per frame, in the same cycle the frame's last bit first appears on s_data.
REQ-022 s_data SHALL hold its last driven value in IDLE and while ser_en=0.
REQ-023 Back-to-back operation: in_ready SHALL be 1 in the cycle after the ser_done edge, so a new word can be accepted with zero idle bit slots wasted beyond that cycle.
REQ-024 ser_en=1 during IDLE SHALL have no effect on s_data or the counter.
REQ-025 Frame latency SHALL be: capture edge, then DATA_WIDTH+PARITY_EN edges with ser_en=1.

Reset
REQ-026 rst=1 at a clock edge SHALL force IDLE, s_data=0, ser_done=0, counter=0, shift register=0 and parity bit=0, overriding every other input.
REQ-027 While reset is applied, in_ready SHALL be 1 and ser_busy SHALL be 0 (state is IDLE).
REQ-028 Reset mid-frame SHALL abort the frame with no ser_done pulse; the next accepted word SHALL start a fresh frame.

Verification
REQ-029 Defaults, p_data=8'hA5, ser_en held at 1 -> s_data emits 1,0,1,0,0,1,0,1 on consecutive cycles; ser_done pulses with the eighth bit; in_ready returns the cycle after.
REQ-030 MSB_FIRST=1, PARITY_EN=1, PARITY_ODD=0, p_data=8'h81 -> s_data emits 1,0,0,0,0,0,0,1, then parity 0; ser_done is on the parity bit only.
REQ-031 PARITY_ODD=1, p_data=8'h07 -> parity bit=0; with p_data=8'h03 -> parity bit=1.
REQ-032 ser_en toggled 1-0-0-1 through a frame -> s_data and the counter hold during the low cycles; total ser_en-high edges until ser_done = DATA_WIDTH(+1).
REQ-033 rst asserted after 3 bits of a frame -> next cycle IDLE, s_data=0, no ser_done; a new word 8'hFF then serializes as eight 1s.
REQ-034 DATA_WIDTH=16, two words presented back-to-back with in_valid held high -> the second word is captured the cycle after the first frame's ser_done, and both frames are bit-exact.
